// File: rtl/param_fifo.sv
`default_nettype none
// ============================================================================
// Module   : param_fifo
// Purpose  : Circular-buffer FIFO with independent push and pop widths.
//            Each push stores WRITE_SIZE elements and each pop removes
//            READ_SIZE elements. Widths are counted in WIDTH-bit elements.
//            It sits between producer and consumer stages of the HE
//            datapath as a width-conversion buffer.
// Ports    : clk_i        - clock; all state updates on the rising edge
//            reset_n_i    - asynchronous active-low reset
//            data_i       - push data; element 0 is the oldest
//            valid_i      - push request
//            ready_o      - there is room for one full push
//            valid_o      - at least READ_SIZE elements are stored
//            data_o       - oldest READ_SIZE elements; element 0 is the oldest
//            next_data_o  - the READ_SIZE elements that follow data_o
//            yumi_i       - pop; the consumer took data_o this cycle
// Revision : 1.0 - initial release
// ============================================================================
module param_fifo #(
  parameter int WIDTH      = 32,
  parameter int WRITE_SIZE = 2,
  parameter int READ_SIZE  = 4,
  parameter int PTR_WIDTH  = 8
) (
  input  logic                                  clk_i,
  input  logic                                  reset_n_i,
  input  logic [WRITE_SIZE-1:0][WIDTH-1:0]      data_i,
  input  logic                                  valid_i,
  output logic                                  ready_o,
  output logic                                  valid_o,
  output logic [READ_SIZE-1:0][WIDTH-1:0]       data_o,
  output logic [READ_SIZE-1:0][WIDTH-1:0]       next_data_o,
  input  logic                                  yumi_i
);

  localparam int c_DEPTH = 1 << PTR_WIDTH;

  // The occupancy count needs one bit more than the pointers so that a
  // completely full buffer can be told apart from an empty one.
  localparam logic [PTR_WIDTH:0] c_DEPTH_CNT = (PTR_WIDTH+1)'(c_DEPTH);
  localparam logic [PTR_WIDTH:0] c_WR_CNT    = (PTR_WIDTH+1)'(WRITE_SIZE);
  localparam logic [PTR_WIDTH:0] c_RD_CNT    = (PTR_WIDTH+1)'(READ_SIZE);

  // Pointer increments are truncated to PTR_WIDTH bits, so a step of a
  // whole DEPTH wraps to zero, which is the correct modulo result.
  localparam logic [PTR_WIDTH-1:0] c_WR_STEP = PTR_WIDTH'(WRITE_SIZE);
  localparam logic [PTR_WIDTH-1:0] c_RD_STEP = PTR_WIDTH'(READ_SIZE);

  logic [WIDTH-1:0]     r_mem [c_DEPTH];
  logic [PTR_WIDTH-1:0] r_wr_ptr;
  logic [PTR_WIDTH-1:0] r_rd_ptr;
  logic [PTR_WIDTH:0]   r_count;

  logic [PTR_WIDTH:0]   w_space;
  logic                 w_push;
  logic                 w_pop;
  logic [PTR_WIDTH:0]   w_count_next;
  logic [PTR_WIDTH-1:0] w_wr_idx [WRITE_SIZE];

  // Flags come only from the registered count; a pop in the same cycle
  // does not free space for a push.
  assign w_space = c_DEPTH_CNT - r_count;
  assign ready_o = (w_space >= c_WR_CNT);
  assign valid_o = (r_count >= c_RD_CNT);

  assign w_push  = valid_i & ready_o;
  assign w_pop   = yumi_i & valid_o;

  always_comb begin
    w_count_next = r_count;
    if (w_push) w_count_next = w_count_next + c_WR_CNT;
    if (w_pop)  w_count_next = w_count_next - c_RD_CNT;
  end

  // Write addresses for each incoming element; PTR_WIDTH-bit arithmetic
  // lets a push straddling the end of storage wrap to the start.
  generate
    for (genvar gi = 0; gi < WRITE_SIZE; gi++) begin : g_wr_idx
      assign w_wr_idx[gi] = r_wr_ptr + PTR_WIDTH'(gi);
    end
  endgenerate

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int k = 0; k < c_DEPTH; k++) begin
        r_mem[k] <= '0;
      end
    end else begin
      if (w_push) begin
        for (int i = 0; i < WRITE_SIZE; i++) begin
          r_mem[w_wr_idx[i]] <= data_i[i];
        end
        r_wr_ptr <= r_wr_ptr + c_WR_STEP;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_RD_STEP;
      end
      r_count <= w_count_next;
    end
  end

  // Read side is purely combinational from storage and rd_ptr, so data
  // pushed on an edge is visible right after that edge.
  generate
    for (genvar gj = 0; gj < READ_SIZE; gj++) begin : g_rd
      logic [PTR_WIDTH-1:0] w_rd_idx;
      logic [PTR_WIDTH-1:0] w_nx_idx;
      assign w_rd_idx       = r_rd_ptr + PTR_WIDTH'(gj);
      assign w_nx_idx       = r_rd_ptr + PTR_WIDTH'(READ_SIZE + gj);
      assign data_o[gj]      = r_mem[w_rd_idx];
      assign next_data_o[gj] = r_mem[w_nx_idx];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_param_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_param_fifo
// Purpose  : Self-checking bench for param_fifo. Two instances are used:
//            u_big with default parameters (DEPTH 256) and u_small with
//            PTR_WIDTH=3 (DEPTH 8) for fill and wrap-around scenarios.
//            Pushed elements go into a per-instance queue and are compared
//            against data_o / next_data_o when the FIFO presents them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_param_fifo;

  logic clk;
  logic rst_n_b, rst_n_s;

  logic [1:0][31:0] din_b, din_s;
  logic             vin_b, vin_s;
  logic             rdy_b, rdy_s;
  logic             vout_b, vout_s;
  logic [3:0][31:0] dout_b, dout_s;
  logic [3:0][31:0] nxt_b, nxt_s;
  logic             yumi_b, yumi_s;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] q_b[$];
  logic [31:0] q_s[$];

  param_fifo u_big (
    .clk_i       (clk),
    .reset_n_i   (rst_n_b),
    .data_i      (din_b),
    .valid_i     (vin_b),
    .ready_o     (rdy_b),
    .valid_o     (vout_b),
    .data_o      (dout_b),
    .next_data_o (nxt_b),
    .yumi_i      (yumi_b)
  );

  param_fifo #(.PTR_WIDTH(3)) u_small (
    .clk_i       (clk),
    .reset_n_i   (rst_n_s),
    .data_i      (din_s),
    .valid_i     (vin_s),
    .ready_o     (rdy_s),
    .valid_o     (vout_s),
    .data_o      (dout_s),
    .next_data_o (nxt_s),
    .yumi_i      (yumi_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle on instance sel (0 = big, 1 = small). Called just after
  // a falling edge; checks flags and presented data against the model,
  // clocks, then updates the model.
  task automatic step(input int sel, input bit v, input logic [31:0] d0,
                      input logic [31:0] d1, input bit y, input string tag);
    int          cnt;
    int          depth;
    bit          push, pop;
    logic [127:0] exp_d, exp_n;
    cnt   = (sel == 0) ? q_b.size() : q_s.size();
    depth = (sel == 0) ? 256 : 8;
    if (sel == 0) begin
      din_b = {d1, d0}; vin_b = v; yumi_b = y;
    end else begin
      din_s = {d1, d0}; vin_s = v; yumi_s = y;
    end
    #1;
    chk({tag, ".ready"}, {127'd0, (sel == 0) ? rdy_b : rdy_s},
        {127'd0, (depth - cnt) >= 2});
    chk({tag, ".valid"}, {127'd0, (sel == 0) ? vout_b : vout_s},
        {127'd0, cnt >= 4});
    if (cnt >= 4) begin
      if (sel == 0) exp_d = {q_b[3], q_b[2], q_b[1], q_b[0]};
      else          exp_d = {q_s[3], q_s[2], q_s[1], q_s[0]};
      chk({tag, ".data"}, (sel == 0) ? dout_b : dout_s, exp_d);
    end
    if (cnt >= 8) begin
      if (sel == 0) exp_n = {q_b[7], q_b[6], q_b[5], q_b[4]};
      else          exp_n = {q_s[7], q_s[6], q_s[5], q_s[4]};
      chk({tag, ".next"}, (sel == 0) ? nxt_b : nxt_s, exp_n);
    end
    push = v && ((depth - cnt) >= 2);
    pop  = y && (cnt >= 4);
    @(posedge clk);
    if (pop) begin
      for (int k = 0; k < 4; k++) begin
        if (sel == 0) void'(q_b.pop_front());
        else          void'(q_s.pop_front());
      end
    end
    if (push) begin
      if (sel == 0) begin q_b.push_back(d0); q_b.push_back(d1); end
      else          begin q_s.push_back(d0); q_s.push_back(d1); end
    end
    @(negedge clk);
    if (sel == 0) begin vin_b = 1'b0; yumi_b = 1'b0; end
    else          begin vin_s = 1'b0; yumi_s = 1'b0; end
  endtask

  initial begin
    rst_n_b = 1'b0; rst_n_s = 1'b0;
    din_b = '0; din_s = '0;
    vin_b = 1'b0; vin_s = 1'b0;
    yumi_b = 1'b0; yumi_s = 1'b0;
    repeat (3) @(negedge clk);
    rst_n_b = 1'b1; rst_n_s = 1'b1;
    #1;

    // Reset state
    chk("rst.valid_b", {127'd0, vout_b}, 128'd0);
    chk("rst.ready_b", {127'd0, rdy_b},  128'd1);
    chk("rst.data_b",  dout_b, 128'd0);
    chk("rst.next_b",  nxt_b,  128'd0);
    chk("rst.valid_s", {127'd0, vout_s}, 128'd0);
    chk("rst.data_s",  dout_s, 128'd0);
    @(negedge clk);

    // Pop while empty must not move rd_ptr
    step(0, 0, 0, 0, 1, "ign_yumi_empty");
    // Three pushes, then a pop attempt on a 2-element residue between
    step(0, 1, 4, 5, 0, "push45");
    step(0, 0, 0, 0, 1, "ign_yumi_residue");
    step(0, 1, 0, 1, 0, "push01");
    chk("main.data_4501", dout_b, {32'd1, 32'd0, 32'd5, 32'd4});
    step(0, 1, 2, 3, 0, "push23");
    // Simultaneous push and pop
    step(0, 1, 6, 7, 1, "push67_pop");
    chk("main.data_2367", dout_b, {32'd7, 32'd6, 32'd3, 32'd2});
    step(0, 0, 0, 0, 1, "pop_last");
    step(0, 0, 0, 0, 0, "empty_after");

    // Fill the small FIFO, then try to push into it while full
    for (int k = 0; k < 4; k++) begin
      step(1, 1, 32'h100 + 2*k, 32'h101 + 2*k, 0, "fill");
    end
    step(1, 1, 32'hDEAD, 32'hBEEF, 0, "push_full");
    step(1, 0, 0, 0, 1, "drain0");
    step(1, 0, 0, 0, 1, "drain1");
    step(1, 0, 0, 0, 0, "drained");

    // Wrap-around: 12 pushes of consecutive values with pops as available
    for (int k = 0; k < 12; k++) begin
      step(1, 1, 32'(2*k), 32'(2*k + 1), 1, "wrap");
    end
    for (int k = 0; k < 4; k++) begin
      step(1, 0, 0, 0, 1, "wrap_drain");
    end
    step(1, 0, 0, 0, 0, "wrap_empty");

    // Asynchronous reset with 6 elements held
    for (int k = 0; k < 3; k++) begin
      step(1, 1, 32'h200 + 2*k, 32'h201 + 2*k, 0, "pre_arst");
    end
    chk("pre_arst.valid", {127'd0, vout_s}, 128'd1);
    chk("pre_arst.ready", {127'd0, rdy_s},  128'd1);
    #1 rst_n_s = 1'b0;
    #1;
    chk("arst.valid", {127'd0, vout_s}, 128'd0);
    chk("arst.ready", {127'd0, rdy_s},  128'd1);
    chk("arst.data",  dout_s, 128'd0);
    chk("arst.next",  nxt_s,  128'd0);
    q_s.delete();
    @(negedge clk);
    rst_n_s = 1'b1;
    step(1, 0, 0, 0, 1, "post_arst");
    step(1, 1, 32'h55, 32'h66, 0, "post_arst_push");
    step(1, 1, 32'h77, 32'h88, 0, "post_arst_push2");
    step(1, 0, 0, 0, 1, "post_arst_pop");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/param_fifo.md
Name: param_fifo

Overview:
Parameterised circular-buffer FIFO whose write and read widths differ.
- Each push enqueues WRITE_SIZE elements; each pop dequeues READ_SIZE elements. Both are counted in WIDTH-bit elements.
- Serves as the width-conversion buffer between producer and consumer stages of the HE datapath.
- Valid/ready on input; valid/yumi (consume-after-look) on output.

Parameters:
WIDTH, 32, bits per element
WRITE_SIZE, 2, elements accepted per push (>=1, <=2^PTR_WIDTH)
READ_SIZE, 4, elements presented and removed per pop (>=1, <=2^PTR_WIDTH)
PTR_WIDTH, 8, pointer width; capacity DEPTH = 2^PTR_WIDTH elements

Ports:
clk_i  in  1  clock, all state on rising edge
reset_n_i  in  1  reset, asynchronous, active-low
data_i  in  WRITE_SIZE x WIDTH (packed [WRITE_SIZE-1:0][WIDTH-1:0])  push data, element 0 is oldest
valid_i  in  1  push request
ready_o  out  1  space for one full push
valid_o  out  1  at least READ_SIZE elements stored
data_o  out  READ_SIZE x WIDTH  oldest READ_SIZE elements, element 0 is oldest
next_data_o  out  READ_SIZE x WIDTH  the READ_SIZE elements following data_o
yumi_i  in  1  pop; consumer took data_o this cycle

Behaviour:
- Clock and reset: one clock, clk_i. Reset reset_n_i is asynchronous, active-low.
- Reset state: wr_ptr=0, rd_ptr=0, count=0, storage cleared to 0.
  - Outputs after reset: valid_o=0, ready_o=1, data_o=0, next_data_o=0.
  - Reset asserted mid-operation discards all contents immediately.
- State: storage of DEPTH elements; wr_ptr and rd_ptr are PTR_WIDTH bits; count is PTR_WIDTH+1 bits.
- ready_o = (DEPTH - count) >= WRITE_SIZE. Combinational from registered count; no pop bypass.
- valid_o = count >= READ_SIZE.
- Push = valid_i & ready_o.
  - Writes data_i[i] to storage[(wr_ptr+i) mod DEPTH] for i in 0..WRITE_SIZE-1.
  - wr_ptr += WRITE_SIZE (mod DEPTH).
  - valid_i while ready_o=0 is ignored; nothing is written.
- Pop = yumi_i & valid_o.
  - rd_ptr += READ_SIZE (mod DEPTH).
  - yumi_i while valid_o=0 is ignored.
- Simultaneous push and pop: both take effect in the same edge.
  - count_next = count + WRITE_SIZE*push - READ_SIZE*pop.
  - Pop data is the pre-edge data_o.
- data_o[j] = storage[(rd_ptr+j) mod DEPTH]. Combinational from registers.
  - Newly pushed elements become visible the cycle after the push edge (zero-cycle read latency after that).
  - Contents are meaningful only when valid_o=1.
- next_data_o[j] = storage[(rd_ptr+READ_SIZE+j) mod DEPTH].
  - Meaningful only when count >= 2*READ_SIZE; otherwise it shows stale storage.
- Wrap-around: all indexing is modulo DEPTH. Pushes and pops that straddle the end of storage split correctly across the boundary.
- No overflow or underflow is possible given the gating above; count never exceeds DEPTH.
- Partial residues: fewer than READ_SIZE elements stay stored with valid_o=0 until later pushes complete a group.

Test Plan:
- Reset: reset_n_i low then high → valid_o=0, ready_o=1, count 0, data_o all 0.
- Defaults, three pushes {4,5}, {0,1}, {2,3} (data_i[0] first) → valid_o=1 after the second push; data_o = 4 5 0 1.
- Simultaneous push {6,7} with yumi_i=1 while data_o = 4 5 0 1 → next cycle data_o = 2 3 6 7, valid_o=1; then pop → valid_o=0, count=0.
- Ignored requests: yumi_i with valid_o=0 → no pointer change. Fill to DEPTH, then valid_i=1 → ready_o=0, data unchanged, count stays DEPTH.
- Wrap-around: PTR_WIDTH=3; push and pop repeatedly, 12 pushes of consecutive values → every popped group is in order across the pointer wrap.
- Async reset mid-stream with count=6 → outputs return to reset values without waiting for a clock edge.
